// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_stall_ctrl.
// The datapath side (master) raises hazard requests; the controller side
// (slave) answers with the stall vector, flush and multi-cycle status.
interface pipeline_stall_ctrl_if;
    logic       stallreq_id;
    logic       ex_mc_start;
    logic       mem_req;
    logic       mem_ack;
    logic       flush_req;
    logic [5:0] stall;
    logic       flush;
    logic       mc_done;
    logic       mc_busy;

    modport master (
        output stallreq_id, ex_mc_start, mem_req, mem_ack, flush_req,
        input  stall, flush, mc_done, mc_busy
    );

    modport slave (
        input  stallreq_id, ex_mc_start, mem_req, mem_ack, flush_req,
        output stall, flush, mc_done, mc_busy
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central hazard controller for the 6-stage pipeline registers.
// Stall vector bits: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB. A held stage whose
// successor is not held injects a bubble into that successor.
// Arbitrates ID load-use stalls, EX multi-cycle ops (latency counter),
// MEM wait-states and EX branch flushes. Priority: MEM > EX > ID.
// Optional feature macro: PIPELINE_STALL_PERF_EN (adds perf_stall_cycles and
// perf_flush_count saturating event counters).
module pipeline_stall_ctrl #(
    parameter int MC_LATENCY = 4,   // 1..255 stall cycles per multi-cycle op
    parameter int CNT_W      = 8    // 2**CNT_W must exceed MC_LATENCY
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_stall_ctrl_if.slave    bus
`ifdef PIPELINE_STALL_PERF_EN
    ,
    output logic [31:0]             perf_stall_cycles,
    output logic [31:0]             perf_flush_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } state_t;

    localparam logic [5:0]       STALL_MEM  = 6'b011111;
    localparam logic [5:0]       STALL_EX   = 6'b001111;
    localparam logic [5:0]       STALL_ID   = 6'b000111;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MC_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             mem_wait;
    logic             id_stall;
    logic             ex_stall;
    logic             mc_done_int;
    logic             flush_int;
    logic [5:0]       stall_int;

    assign mem_wait = bus.mem_req & ~bus.mem_ack;

    // State and latency-counter register; synchronous reset discards any in-flight op.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values regardless of statement order.
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter and hazard arbitration.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next  = state;
        cnt_next    = cnt;
        ex_stall    = 1'b0;
        id_stall    = 1'b0;
        mc_done_int = 1'b0;
        flush_int   = 1'b0;

        case (state)
            IDLE: begin
                // A squashed instruction never stalls, so flush_req masks ID.
                id_stall  = bus.stallreq_id & ~bus.flush_req;
                flush_int = bus.flush_req & ~mem_wait;
                if (bus.ex_mc_start) begin
                    ex_stall = 1'b1;
                    if (MC_LATENCY == 1) begin
                        state_next = MC_DONE;
                    end else begin
                        state_next = MC_BUSY;
                        cnt_next   = CNT_RELOAD;
                    end
                end
            end
            MC_BUSY: begin
                // The divider runs independently of MEM wait-states.
                ex_stall = 1'b1;
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_ONE;
                end
                if (cnt == CNT_ONE) begin
                    state_next = MC_DONE;
                end
            end
            MC_DONE: begin
                // Result write-back waits until MEM releases the pipeline.
                if (!mem_wait) begin
                    mc_done_int = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (mem_wait) begin
            stall_int = STALL_MEM;
        end else if (ex_stall) begin
            stall_int = STALL_EX;
        end else if (id_stall) begin
            stall_int = STALL_ID;
        end else begin
            stall_int = 6'b000000;
        end
    end

    // Outputs are forced quiet while reset is asserted.
    assign bus.stall   = reset ? 6'b000000 : stall_int;
    assign bus.flush   = ~reset & flush_int;
    assign bus.mc_done = ~reset & mc_done_int;
    assign bus.mc_busy = ~reset & ((state == MC_BUSY) | (state == MC_DONE));

`ifdef PIPELINE_STALL_PERF_EN
    // Saturating counters of stalled PC cycles and issued flushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (bus.stall[0] && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (bus.flush && (perf_flush_count != 32'hFFFF_FFFF)) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl (MC_LATENCY=4). The stimulus
// process drives one directed vector per cycle and queues the hand-computed
// response; the monitor pops and compares on the falling edge.
module tb_pipeline_stall_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    pipeline_stall_ctrl_if bus ();

`ifdef PIPELINE_STALL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
`endif

    pipeline_stall_ctrl #(
        .MC_LATENCY (4),
        .CNT_W      (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus.slave)
`ifdef PIPELINE_STALL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected response: {stall[5:0], flush, mc_done, mc_busy}
    typedef struct {
        string      name;
        logic [8:0] exp;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One cycle: in = {reset, stallreq_id, ex_mc_start, mem_req, mem_ack, flush_req}
    task automatic step(input string name, input logic [5:0] in, input logic [8:0] exp);
        @(posedge clk);
        #1;
        reset           = in[5];
        bus.stallreq_id = in[4];
        bus.ex_mc_start = in[3];
        bus.mem_req     = in[2];
        bus.mem_ack     = in[1];
        bus.flush_req   = in[0];
        sb_q.push_back('{name: name, exp: exp});
    endtask

    // Monitor: the controller presents a response every cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (!reset) begin
                assert (!(bus.flush_req && bus.ex_mc_start))
                    else $error("illegal flush_req with ex_mc_start");
            end
            check(e.name, {23'd0, bus.stall, bus.flush, bus.mc_done, bus.mc_busy},
                  {23'd0, e.exp});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        reset           = 1'b1;
        bus.stallreq_id = 1'b0;
        bus.ex_mc_start = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.flush_req   = 1'b0;

        // T1: reset with every request high keeps all outputs quiet
        for (int i = 0; i < 3; i++) step("t1_reset", 6'b111111, 9'b000000_000);

        // T2: single-cycle load-use stall
        step("t2_id_stall", 6'b010000, 9'b000111_000);
        step("t2_release",  6'b000000, 9'b000000_000);

        // T3: multi-cycle op, 4 EX stall cycles then mc_done; ID request absorbed
        step("t3_c0",       6'b001000, 9'b001111_000);
        step("t3_c1",       6'b000000, 9'b001111_001);
        step("t3_c2_idabs", 6'b010000, 9'b001111_001);
        step("t3_c3",       6'b000000, 9'b001111_001);
        step("t3_c4_done",  6'b000000, 9'b000000_011);
        step("t3_c5_idle",  6'b000000, 9'b000000_000);

        // T4: MEM wait-state over cycles 3-5 delays mc_done to cycle 6
        step("t4_c0",       6'b001000, 9'b001111_000);
        step("t4_c1",       6'b000000, 9'b001111_001);
        step("t4_c2",       6'b000000, 9'b001111_001);
        step("t4_c3_mem",   6'b000100, 9'b011111_001);
        step("t4_c4_mem",   6'b000100, 9'b011111_001);
        step("t4_c5_mem",   6'b000100, 9'b011111_001);
        step("t4_c6_done",  6'b000000, 9'b000000_011);
        step("t4_c7_idle",  6'b000000, 9'b000000_000);

        // T5: flush squashes the ID stall; flush deferred by MEM wait
        step("t5_flush_id", 6'b010001, 9'b000000_100);
        step("t5_defer0",   6'b000101, 9'b011111_000);
        step("t5_defer1",   6'b000101, 9'b011111_000);
        step("t5_ack",      6'b000111, 9'b000000_100);
        step("t5_idle",     6'b000000, 9'b000000_000);

        // T6: reset in the middle of a multi-cycle op discards it
        step("t6_pre_reset", 6'b100000, 9'b000000_000);
        step("t6_c0",        6'b001000, 9'b001111_000);
        step("t6_c1",        6'b000000, 9'b001111_001);
`ifdef PIPELINE_STALL_PERF_EN
        #2 check("t6_perf_before", perf_stall_cycles, 32'd1);
`endif
        step("t6_c2_reset",  6'b100000, 9'b000000_000);
`ifdef PIPELINE_STALL_PERF_EN
        #2 check("t6_perf_at_reset", perf_stall_cycles, 32'd2);
`endif
        step("t6_c3",        6'b000000, 9'b000000_000);
`ifdef PIPELINE_STALL_PERF_EN
        #2 check("t6_perf_cleared", perf_stall_cycles, 32'd0);
`endif
        for (int i = 0; i < 5; i++) step("t6_no_done", 6'b000000, 9'b000000_000);

        // Let the monitor drain the scoreboard
        for (int i = 0; i < 3 && sb_q.size() > 0; i++) @(posedge clk);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
